// File: rtl/ram_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : ram_io_responder
// Description : Responder end of the byte-serial memory bus. Serves one byte
//               per cycle from an on-chip byte RAM or a small I/O window that
//               holds a TX byte FIFO toward the host and a one-byte RX
//               holding register fed by the host.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_io_responder #(
    parameter int ADDR_WIDTH  = 17,
    parameter int FIFO_DEPTH  = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rw_select,
    input  logic [31:0] addr_in,
    input  logic [7:0]  ram_store_data,
    output logic [7:0]  ram_load_data,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        io_overflow
);

    localparam int                 c_ptr_w       = $clog2(FIFO_DEPTH);
    localparam int                 c_cnt_w       = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth       = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_full_thresh = c_cnt_w'(FIFO_DEPTH - FULL_MARGIN);
    localparam logic [2:0]         c_off_data    = 3'd0;
    localparam logic [2:0]         c_off_status  = 3'd4;

    // Storage
    logic [7:0]            r_ram  [0:(2**ADDR_WIDTH)-1];
    logic [7:0]            r_fifo [0:FIFO_DEPTH-1];

    // Registered state
    logic [7:0]            r_load;
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;
    logic                  r_buf_full;
    logic                  r_overflow;
    logic                  r_rx_full;
    logic [7:0]            r_rx_byte;

    // Decode and handshake wires
    logic                  w_is_io;
    logic [2:0]            w_off;
    logic [ADDR_WIDTH-1:0] w_ram_idx;
    logic                  w_ram_wr;
    logic                  w_push_req;
    logic                  w_push_ok;
    logic                  w_tx_pop;
    logic                  w_rx_pop;
    logic                  w_rx_take;
    logic [c_cnt_w-1:0]    w_next_count;
    logic [7:0]            w_io_rd_data;
    logic                  w_unused_addr;

    // Only the I/O decode bits and the RAM index are meaningful; the rest of
    // the bus address is deliberately ignored so addresses wrap.
    assign w_unused_addr = ^addr_in;

    assign w_is_io    = (addr_in[17:16] == 2'b11);
    assign w_off      = addr_in[2:0];
    assign w_ram_idx  = addr_in[ADDR_WIDTH-1:0];

    assign tx_valid   = (r_count != '0);
    assign tx_data    = r_fifo[r_rd_ptr];
    assign rx_ready   = !r_rx_full;
    assign io_buffer_full = r_buf_full;
    assign io_overflow    = r_overflow;
    assign ram_load_data  = r_load;

    // Every side effect is gated by rdy_in so a stalled bus freezes all state.
    assign w_ram_wr   = rdy_in && rw_select && !w_is_io;
    assign w_push_req = rdy_in && rw_select && w_is_io && (w_off == c_off_data);
    assign w_tx_pop   = rdy_in && tx_valid && tx_ready;
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign w_push_ok  = w_push_req && ((r_count != c_depth) || w_tx_pop);
    assign w_rx_pop   = rdy_in && !rw_select && w_is_io && (w_off == c_off_data) && r_rx_full;
    // A byte popped this cycle leaves rx_ready low, so a same-cycle offer is refused.
    assign w_rx_take  = rdy_in && rx_valid && !r_rx_full;

    // Next FIFO occupancy, used both for the count and for the near-full flag
    always_comb begin
        w_next_count = r_count;
        if (w_push_ok && !w_tx_pop) begin
            w_next_count = r_count + 1'b1;
        end else if (!w_push_ok && w_tx_pop) begin
            w_next_count = r_count - 1'b1;
        end
    end

    // I/O read mux; status reflects the registered flags before this edge
    always_comb begin
        w_io_rd_data = 8'h00;
        case (w_off)
            c_off_data:   w_io_rd_data = r_rx_full ? r_rx_byte : 8'h00;
            c_off_status: w_io_rd_data = {5'b0, r_overflow, r_buf_full, r_rx_full};
            default:      w_io_rd_data = 8'h00;
        endcase
    end

    // RAM array write port; contents survive reset
    always_ff @(posedge clk_in) begin
        if (w_ram_wr) begin
            r_ram[w_ram_idx] <= ram_store_data;
        end
    end

    // Registered read byte; a RAM write cycle returns the byte being replaced
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_load <= 8'h00;
        end else if (rdy_in) begin
            if (!w_is_io) begin
                r_load <= r_ram[w_ram_idx];
            end else if (!rw_select) begin
                r_load <= w_io_rd_data;
            end
        end
    end

    // TX FIFO storage
    always_ff @(posedge clk_in) begin
        if (w_push_ok) begin
            r_fifo[r_wr_ptr] <= ram_store_data;
        end
    end

    // TX FIFO pointers, occupancy, near-full flag and sticky overflow
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_buf_full <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_tx_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count    <= w_next_count;
            r_buf_full <= (w_next_count >= c_full_thresh);
            if (w_push_req && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // RX holding register: filled by the host, emptied by an I/O data read
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rx_full <= 1'b0;
            r_rx_byte <= 8'h00;
        end else if (w_rx_pop) begin
            r_rx_full <= 1'b0;
        end else if (w_rx_take) begin
            r_rx_full <= 1'b1;
            r_rx_byte <= rx_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_io_responder
// Description : Directed bench for ram_io_responder with a queue-based model
//               and per-cycle output comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_io_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rw;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  load;
    logic        buf_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_io_responder dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .rdy_in         (rdy),
        .rw_select      (rw),
        .addr_in        (addr),
        .ram_store_data (wdata),
        .ram_load_data  (load),
        .io_buffer_full (buf_full),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .io_overflow    (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: sparse RAM, byte queue for TX, flag+byte for RX
    logic [7:0] m_ram [int];
    logic [7:0] m_txq [$];
    logic [7:0] m_load;
    bit         m_load_known;
    bit         m_ovf;
    bit         m_full;
    bit         m_rxf;
    logic [7:0] m_rxb;
    bit         chk_en = 1'b0;

    always @(posedge clk) begin : model
        bit         io;
        bit         pop;
        bit         rx_pop;
        int         idx;
        logic [2:0] off;
        logic [7:0] status;
        if (rst) begin
            m_txq.delete();
            m_load = 8'h00;
            m_load_known = 1'b1;
            m_ovf = 1'b0;
            m_full = 1'b0;
            m_rxf = 1'b0;
        end else if (rdy) begin
            io     = (addr[17:16] == 2'b11);
            off    = addr[2:0];
            idx    = int'(addr[16:0]);
            status = {5'b0, m_ovf, m_full, m_rxf};
            pop    = (m_txq.size() != 0) && tx_ready;
            rx_pop = 1'b0;
            if (!io) begin
                if (m_ram.exists(idx)) begin
                    m_load = m_ram[idx];
                    m_load_known = 1'b1;
                end else begin
                    m_load_known = 1'b0;
                end
                if (rw) m_ram[idx] = wdata;
            end else if (!rw) begin
                m_load_known = 1'b1;
                if (off == 3'd0) begin
                    if (m_rxf) begin
                        m_load = m_rxb;
                        rx_pop = 1'b1;
                    end else begin
                        m_load = 8'h00;
                    end
                end else if (off == 3'd4) begin
                    m_load = status;
                end else begin
                    m_load = 8'h00;
                end
            end
            if (pop) void'(m_txq.pop_front());
            if (io && rw && off == 3'd0) begin
                if (m_txq.size() < 8) m_txq.push_back(wdata);
                else m_ovf = 1'b1;
            end
            m_full = (m_txq.size() >= 6);
            if (rx_pop) m_rxf = 1'b0;
            else if (rx_valid && !m_rxf) begin
                m_rxb = rx_data;
                m_rxf = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            if (m_load_known) chk("model_load", load, m_load);
            chk("model_tx_valid", tx_valid, m_txq.size() != 0);
            if (m_txq.size() != 0) chk("model_tx_data", tx_data, m_txq[0]);
            chk("model_buf_full", buf_full, m_full);
            chk("model_rx_ready", rx_ready, !m_rxf);
            chk("model_overflow", overflow, m_ovf);
        end
    end

    task automatic drive(input logic w, input logic [31:0] a, input logic [7:0] d,
                         input logic txr = 1'b0, input logic rxv = 1'b0,
                         input logic [7:0] rxd = 8'h00, input logic rd = 1'b1);
        rw = w; addr = a; wdata = d; tx_ready = txr;
        rx_valid = rxv; rx_data = rxd; rdy = rd;
        @(negedge clk);
    endtask

    logic [7:0] exp_drain [8] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h77};

    initial begin
        rst = 1'b1; rdy = 1'b1; rw = 1'b0; addr = '0; wdata = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_load", load, 8'h00);
        chk("reset_tx_valid", tx_valid, 1'b0);
        chk("reset_buf_full", buf_full, 1'b0);
        chk("reset_rx_ready", rx_ready, 1'b1);
        chk("reset_overflow", overflow, 1'b0);
        rst = 1'b0;

        // Write then burst-read four bytes
        drive(1'b1, 32'h100, 8'h44);
        drive(1'b1, 32'h101, 8'h33);
        drive(1'b1, 32'h102, 8'h22);
        drive(1'b1, 32'h103, 8'h11);
        drive(1'b0, 32'h100, 8'h00); chk("burst_0", load, 8'h44);
        drive(1'b0, 32'h101, 8'h00); chk("burst_1", load, 8'h33);
        drive(1'b0, 32'h102, 8'h00); chk("burst_2", load, 8'h22);
        drive(1'b0, 32'h103, 8'h00); chk("burst_3", load, 8'h11);

        // Write cycle returns the old byte
        drive(1'b1, 32'h200, 8'h5A);
        drive(1'b1, 32'h200, 8'hAB); chk("rdw_old", load, 8'h5A);
        drive(1'b0, 32'h200, 8'h00); chk("rdw_new", load, 8'hAB);

        // Fill TX FIFO with the host stalled
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h30000, 8'(8'h10 + i));
            if (i == 4) chk("full_after5", buf_full, 1'b0);
        end
        chk("full_after6", buf_full, 1'b1);
        drive(1'b1, 32'h30000, 8'h16);
        drive(1'b1, 32'h30000, 8'h17); chk("ovf_after8", overflow, 1'b0);
        drive(1'b1, 32'h30000, 8'h18); chk("ovf_after9", overflow, 1'b1);

        // Push into a full FIFO with a simultaneous pop
        drive(1'b1, 32'h30000, 8'h77, 1'b1);
        chk("full_push_pop_head", tx_data, 8'h11);
        chk("full_push_pop_full", buf_full, 1'b1);

        // Stalled bus must not consume the handshake
        drive(1'b0, 32'h100, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("stall_head", tx_data, 8'h11);

        for (int i = 0; i < 8; i++) begin
            chk("drain_order", tx_data, exp_drain[i]);
            drive(1'b0, 32'h100, 8'h00, 1'b1);
        end
        chk("drain_empty", tx_valid, 1'b0);

        // Non-zero I/O write offset is ignored
        drive(1'b1, 32'h30001, 8'h55);
        chk("io_wr_off1", tx_valid, 1'b0);

        // Reset with bytes queued
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h30000, 8'(8'h20 + i));
        chk("queued5", tx_valid, 1'b1);
        rst = 1'b1;
        drive(1'b0, 32'h100, 8'h00);
        rst = 1'b0;
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_buf_full", buf_full, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        drive(1'b0, 32'h100, 8'h00); chk("ram_kept", load, 8'h44);

        // Address wrap and ignored upper bits
        drive(1'b1, 32'h20100, 8'h99); chk("wrap_old", load, 8'h44);
        drive(1'b0, 32'hFF000100, 8'h00); chk("wrap_read", load, 8'h99);

        // RX holding register
        drive(1'b0, 32'h100, 8'h00, 1'b0, 1'b1, 8'h41);
        chk("rx_taken", rx_ready, 1'b0);
        drive(1'b0, 32'h30004, 8'h00); chk("status", load, 8'h01);
        drive(1'b0, 32'h30000, 8'h00); chk("rx_pop", load, 8'h41);
        chk("rx_ready_after_pop", rx_ready, 1'b1);
        drive(1'b0, 32'h30000, 8'h00); chk("rx_empty_read", load, 8'h00);
        drive(1'b0, 32'h30002, 8'h00); chk("io_rd_off2", load, 8'h00);
        drive(1'b0, 32'h100, 8'h00, 1'b0, 1'b1, 8'h42);
        drive(1'b0, 32'h30000, 8'h00, 1'b0, 1'b1, 8'h43);
        chk("rx_pop_old", load, 8'h42);
        chk("rx_offer_refused", rx_ready, 1'b1);
        drive(1'b0, 32'h100, 8'h00, 1'b0, 1'b1, 8'h43);
        chk("rx_reoffer", rx_ready, 1'b0);
        drive(1'b0, 32'h30000, 8'h00); chk("rx_pop_new", load, 8'h43);

        drive(1'b0, 32'h100, 8'h00);
        drive(1'b0, 32'h100, 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
